// File: rtl/bitmod_mul_front_pkg.sv
// bitmod_mul_front_pkg
//   Shared constants for the modular-multiply front end. The multiplier
//   pipeline depth default lives here so that lane control and the
//   multiplier agree on the build configuration.
//   Also holds a small helper for the canonical-range check.
package bitmod_mul_front_pkg;

  localparam int DW_DEF             = 12;    // operand width
  localparam int TAGW_DEF           = 4;     // sideband tag width
  localparam int Q_DEF              = 3329;  // modulus, used for range check only
  localparam int MUL_STAGES_DEFAULT = 2;     // registered multiplier stages (1 or 2)

  // True when an operand lies outside the canonical residue range [0, q-1].
  function automatic logic out_of_range(input int unsigned v, input int unsigned q);
    return v >= q;
  endfunction

endpackage

// File: rtl/bitmod_mul_front_pp_split_mul.sv
// pp_split_mul
//   Combinational DW x (DW/2) unsigned partial-product generator. The
//   front end instantiates it twice, once per half of the multiplier
//   operand, so each stage-1 product stays narrow.
// Ports:
//   a : DW-bit multiplicand
//   b : DW/2-bit slice of the multiplier
//   p : DW + DW/2 bit exact product a*b
module pp_split_mul #(
  parameter int DW = 12,
  parameter int HW = DW / 2
) (
  input  logic [DW-1:0]    a,
  input  logic [HW-1:0]    b,
  output logic [DW+HW-1:0] p
);

  // Extend both operands to the result width so the product is exact.
  assign p = {{HW{1'b0}}, a} * {{DW{1'b0}}, b};

endmodule

// File: rtl/bitmod_mul_front.sv
// bitmod_mul_front
//   Elastic pipelined DW x DW unsigned multiplier feeding the 24-bit
//   mod-Q reducer. Operands arrive with valid/ready, the product leaves
//   with valid/ready, and a tag rides alongside each operation.
// Ports:
//   clk, rst            : rising-edge clock, async active-high reset
//   in_valid / in_ready : input handshake (in_ready is combinational)
//   in_a, in_b, in_tag  : operands and sideband tag, sampled on accept
//   out_valid/out_ready : output handshake
//   out_C, out_tag      : registered product and its tag
//   range_err           : sticky, some accepted operand was >= Q
//   busy                : any pipeline stage holds an operation
module bitmod_mul_front
  import bitmod_mul_front_pkg::*;
#(
  parameter int DW         = DW_DEF,
  parameter int TAGW       = TAGW_DEF,
  parameter int Q          = Q_DEF,
  parameter int MUL_STAGES = MUL_STAGES_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_a,
  input  logic [DW-1:0]   in_b,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] out_C,
  output logic [TAGW-1:0] out_tag,
  output logic            range_err,
  output logic            busy
);

  localparam int HW  = DW / 2;   // multiplier split point
  localparam int PPW = DW + HW;  // partial-product width

  logic           accept;
  logic [PPW-1:0] pp_lo;
  logic [PPW-1:0] pp_hi;

  assign accept = in_valid & in_ready;

  pp_split_mul #(.DW(DW), .HW(HW)) u_pp_lo (
    .a (in_a),
    .b (in_b[HW-1:0]),
    .p (pp_lo)
  );

  pp_split_mul #(.DW(DW), .HW(HW)) u_pp_hi (
    .a (in_a),
    .b (in_b[DW-1:HW]),
    .p (pp_hi)
  );

  // Sticky range flag; the offending operation still flows through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      range_err <= 1'b0;
    end else if (accept &&
                 (out_of_range(32'(in_a), Q) || out_of_range(32'(in_b), Q))) begin
      range_err <= 1'b1;
    end
  end

  if (MUL_STAGES == 2 && (DW % 2) == 0) begin : g_two_stage
    logic           s1_valid;
    logic           s2_valid;
    logic [PPW-1:0] pp_lo_q;
    logic [PPW-1:0] pp_hi_q;
    logic [TAGW-1:0] tag_q;
    logic           s2_load;
    logic           s1_adv;

    // Ready propagates backwards from out_ready through the valid chain;
    // there is no skid buffer, so this path is purely combinational.
    assign s2_load  = !s2_valid | out_ready;
    assign s1_adv   = s1_valid & s2_load;
    assign in_ready = !s1_valid | s1_adv;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would let s2 see s1's new data.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
        pp_lo_q  <= '0;
        pp_hi_q  <= '0;
        tag_q    <= '0;
        out_C    <= '0;
        out_tag  <= '0;
      end else begin
        if (in_ready) s1_valid <= in_valid;
        if (accept) begin
          pp_lo_q <= pp_lo;
          pp_hi_q <= pp_hi;
          tag_q   <= in_tag;
        end
        if (s2_load) s2_valid <= s1_valid;
        // Output registers only change when s1 hands over, which keeps
        // out_C/out_tag stable while a product waits for out_ready.
        if (s1_adv) begin
          out_C   <= {{HW{1'b0}}, pp_lo_q} + ({{HW{1'b0}}, pp_hi_q} << HW);
          out_tag <= tag_q;
        end
      end
    end

    assign out_valid = s2_valid;
    assign busy      = s1_valid | s2_valid;

  end else if (MUL_STAGES == 1 && (DW % 2) == 0) begin : g_one_stage
    logic s1_valid;

    assign in_ready = !s1_valid | out_ready;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_valid <= 1'b0;
        out_C    <= '0;
        out_tag  <= '0;
      end else begin
        if (in_ready) s1_valid <= in_valid;
        if (accept) begin
          out_C   <= {{HW{1'b0}}, pp_lo} + ({{HW{1'b0}}, pp_hi} << HW);
          out_tag <= in_tag;
        end
      end
    end

    assign out_valid = s1_valid;
    assign busy      = s1_valid;

  end else begin : g_bad_config
    $error("bitmod_mul_front: MUL_STAGES must be 1 or 2 and DW must be even");
  end

endmodule

// File: tb/tb_bitmod_mul_front.sv
// tb_bitmod_mul_front
//   Scoreboard bench: the driver pushes the hand-computed product and tag
//   of every accepted operation; an independent monitor pops and compares
//   on every output transfer.
module tb_bitmod_mul_front;

  localparam int DW     = 12;
  localparam int TAGW   = 4;
  localparam int STAGES = 2;

  typedef struct {
    logic [2*DW-1:0] c;
    logic [TAGW-1:0] tag;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_a;
  logic [DW-1:0]   in_b;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [2*DW-1:0] out_C;
  logic [TAGW-1:0] out_tag;
  logic            range_err;
  logic            busy;

  exp_t sb[$];
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   n_xfer   = 0;
  int   stalls   = 0;
  bit   soak_on  = 1'b0;

  bitmod_mul_front #(.MUL_STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_C     (out_C),
    .out_tag   (out_tag),
    .range_err (range_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Present one operation from a falling edge and hold it until accepted.
  // Acceptance is judged just before the rising edge, when in_ready is settled.
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [2*DW-1:0] c, input logic [TAGW-1:0] t);
    exp_t e;
    bit   ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_tag   = t;
    for (int i = 0; i < 200; i++) begin
      #2;
      if (in_ready) begin
        e.c   = c;
        e.tag = t;
        sb.push_back(e);
        ok = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        break;
      end
      stalls++;
      @(negedge clk);
    end
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end
  endtask

  // After send() returns, out_valid must be low for STAGES-1 falling
  // edges and high on the STAGES-th.
  task automatic check_latency(input string name);
    for (int k = 1; k < STAGES; k++) begin
      @(negedge clk);
      check({name, "_early"}, 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  // Monitor: a transfer happens at the next rising edge whenever both
  // out_valid and out_ready are high shortly before it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (out_valid && out_ready && !rst) begin
        n_xfer++;
        if (sb.size() == 0) begin
          check("unexpected_output", 32'(out_C), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("out_C", 32'(out_C), 32'(e.c));
          check("out_tag", 32'(out_tag), 32'(e.tag));
        end
      end
    end
  end

  // Random backpressure, only while the soak phase owns out_ready.
  initial begin
    forever begin
      @(negedge clk);
      if (soak_on) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int base;
    bit exp_err;
    logic [DW-1:0] a, b;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_range_err", 32'(range_err), 32'd0);
    check("rst_out_C", 32'(out_C), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);

    // Single operation and its latency.
    out_ready = 1'b1;
    send(12'd17, 12'd19, 24'h000143, 4'd3);
    check_latency("single");
    check("single_range_err", 32'(range_err), 32'd0);

    // Largest canonical operands, then out-of-range operands.
    send(12'd3328, 12'd3328, 24'hA90000, 4'd5);
    check("max_canon_range_err", 32'(range_err), 32'd0);
    send(12'd4095, 12'd4095, 24'hFFE001, 4'd6);
    check("oor_range_err", 32'(range_err), 32'd1);
    repeat (4) @(negedge clk);
    check("oor_range_err_sticky", 32'(range_err), 32'd1);

    // Back-to-back streaming with out_ready held high.
    stalls = 0;
    base   = n_xfer;
    for (int i = 0; i < 16; i++)
      send(DW'(i), DW'(i + 1), 24'(i * (i + 1)), TAGW'(i));
    repeat (STAGES + 1) @(negedge clk);
    #4;
    check("stream_stalls", 32'(stalls), 32'd0);
    check("stream_xfers", 32'(n_xfer - base), 32'd16);

    // Backpressure: two accepts fill the pipeline, then in_ready drops
    // and the head product is held stable.
    out_ready = 1'b0;
    send(12'd100, 12'd200, 24'd20000, 4'd8);
    send(12'd300, 12'd400, 24'd120000, 4'd9);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #2;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_C_hold", 32'(out_C), 32'd20000);
      check("bp_out_tag_hold", 32'(out_tag), 32'd8);
    end
    fork
      send(12'd500, 12'd600, 24'd300000, 4'd10);
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    send(12'd700, 12'd800, 24'd560000, 4'd11);
    repeat (STAGES + 3) @(negedge clk);
    check("bp_drained", 32'(sb.size()), 32'd0);

    // Reset with two operations in flight discards them.
    out_ready = 1'b0;
    send(12'd11, 12'd13, 24'd143, 4'd1);
    send(12'd21, 12'd23, 24'd483, 4'd2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_range_err", 32'(range_err), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    send(12'd5, 12'd7, 24'd35, 4'd7);
    check_latency("post_rst");

    // Random operands with random gaps and random backpressure.
    exp_err = 1'b0;
    soak_on = 1'b1;
    for (int i = 0; i < 200; i++) begin
      a = DW'($urandom_range(0, 4095));
      b = DW'($urandom_range(0, 4095));
      if (a >= 12'd3329 || b >= 12'd3329) exp_err = 1'b1;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send(a, b, 24'(a) * 24'(b), TAGW'(i));
    end
    soak_on = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 100 && (sb.size() != 0 || busy); i++) @(negedge clk);
    #4;
    check("soak_range_err", 32'(range_err), 32'(exp_err));
    check("final_queue_empty", 32'(sb.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
